// File: rtl/wash_pkg.sv
// Shared configuration, state encoding and per-mode price/duration helpers for the wash controller.
// Mode i defaults: price = PRICE_BASE + i*PRICE_STEP, duration = DUR_BASE + i*DUR_STEP seconds.
package wash_pkg;
  localparam int NUM_MODES  = 4;
  localparam int PRICE_W    = 9;
  localparam int BAL_W      = 10;
  localparam int TIME_W     = 8;
  localparam int PRICE_BASE = 20;
  localparam int PRICE_STEP = 10;
  localparam int DUR_BASE   = 30;
  localparam int DUR_STEP   = 15;
  localparam int FINE_WAIT  = 60;
  localparam int FINE_RATE  = 1;
  localparam int MODE_W     = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [PRICE_W-1:0] def_price(input int unsigned i);
    return PRICE_W'(PRICE_BASE + i * PRICE_STEP);
  endfunction

  function automatic logic [TIME_W-1:0] dur(input int unsigned i);
    return TIME_W'(DUR_BASE + i * DUR_STEP);
  endfunction

  // Out-of-range selections fall back to mode 0.
  function automatic logic [MODE_W-1:0] mode_idx(input logic [MODE_W-1:0] m);
    return (32'(m) < NUM_MODES) ? m : '0;
  endfunction

  function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] a,
                                               input logic [PRICE_W-1:0] b);
    logic [BAL_W:0] s;
    s = {1'b0, a} + (BAL_W+1)'(b);
    return s[BAL_W] ? '1 : s[BAL_W-1:0];
  endfunction
endpackage

// File: rtl/wash_countdown.sv
// Loadable seconds down-counter: clr beats load beats tick, holds at zero.
// last flags the tick that takes the count from 1 to 0.
module wash_countdown
  import wash_pkg::*;
#(
  parameter int W = TIME_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         last
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (load)
      cnt_d = load_val;
    else if (tick && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign last = tick && (cnt_q == W'(1));
endmodule

// File: rtl/wash_cycle_ctrl.sv
// Wash-cycle sequencer and billing engine: mode pricing, saturating balance, countdown, cancel refunds.
// Overtime fines after DONE are built only when WASH_FINE_EN is defined.
module wash_cycle_ctrl
  import wash_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1hz,
  input  logic [MODE_W-1:0]  mode_sel,
  input  logic               use_default,
  input  logic               price_wr,
  input  logic [PRICE_W-1:0] price_in,
  input  logic               coin_valid,
  input  logic [PRICE_W-1:0] coin_amt,
  input  logic               start,
  input  logic               cancel,
  input  logic               collect,
  output logic [1:0]         state,
  output logic [BAL_W-1:0]   balance,
  output logic [TIME_W-1:0]  remaining,
  output logic               insufficient,
  output logic               done,
  output logic [PRICE_W-1:0] fine_amt,
  output logic               is_fine
);
  state_e             state_q, state_d;
  logic [BAL_W-1:0]   bal_q, bal_d, bal_coin, fine_ded;
  logic               ins_q, ins_d, fine_block;
  logic [PRICE_W-1:0] tbl_q [NUM_MODES];
  logic [PRICE_W-1:0] tbl_d [NUM_MODES];
  logic [PRICE_W-1:0] lat_price_q, lat_price_d, sel_price, coin_eff, coin_net;
  logic [TIME_W-1:0]  lat_dur_q, lat_dur_d, rem_cnt;
  logic [MODE_W-1:0]  idx;
  logic               rem_load, rem_tick, rem_clr, rem_last;

  assign idx       = mode_idx(mode_sel);
  assign sel_price = use_default ? def_price(32'(idx)) : tbl_q[idx];
  assign coin_eff  = coin_valid ? coin_amt : '0;
  assign bal_coin  = sat_add(bal_q, coin_net);
  // cancel wins over a same-cycle tick, so the countdown never sees both.
  assign rem_tick  = (state_q == RUN) && tick_1hz && !cancel;
  assign rem_clr   = (state_q == RUN) && cancel;

  wash_countdown #(.W(TIME_W)) u_rem (
    .clk      (clk),
    .rst_n    (rst),
    .load     (rem_load),
    .load_val (dur(32'(idx))),
    .tick     (rem_tick),
    .clr      (rem_clr),
    .cnt      (rem_cnt),
    .last     (rem_last)
  );

`ifdef WASH_FINE_EN
  logic [PRICE_W-1:0] fine_q, fine_d, fine_pay;
  logic [PRICE_W:0]   fine_sum;
  logic [TIME_W-1:0]  ot_cnt;
  logic               ot_last_unused;

  // Coins settle an outstanding fine before they reach the balance.
  assign fine_pay   = (coin_eff < fine_q) ? coin_eff : fine_q;
  assign coin_net   = coin_eff - fine_pay;
  assign fine_block = (fine_q != '0);

  wash_countdown #(.W(TIME_W)) u_overtime (
    .clk      (clk),
    .rst_n    (rst),
    .load     (rem_last),
    .load_val (TIME_W'(FINE_WAIT)),
    .tick     (tick_1hz && (state_q == DONE)),
    .clr      (1'b0),
    .cnt      (ot_cnt),
    .last     (ot_last_unused)
  );

  always_comb begin
    fine_d   = fine_q - fine_pay;
    fine_sum = '0;
    fine_ded = '0;
    if (state_q == DONE) begin
      if (tick_1hz && (ot_cnt == '0)) begin
        fine_sum = {1'b0, fine_d} + (PRICE_W+1)'(FINE_RATE);
        fine_d   = fine_sum[PRICE_W] ? '1 : fine_sum[PRICE_W-1:0];
      end
      if (collect) begin
        fine_ded = (BAL_W'(fine_d) < bal_coin) ? BAL_W'(fine_d) : bal_coin;
        fine_d   = fine_d - PRICE_W'(fine_ded);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      fine_q <= '0;
    else
      fine_q <= fine_d;
  end

  assign fine_amt = fine_q;
  assign is_fine  = (fine_q != '0);
`else
  assign coin_net   = coin_eff;
  assign fine_block = 1'b0;
  assign fine_ded   = '0;
  assign fine_amt   = '0;
  assign is_fine    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bal_d       = bal_coin;
    ins_d       = 1'b0;
    tbl_d       = tbl_q;
    lat_price_d = lat_price_q;
    lat_dur_d   = lat_dur_q;
    rem_load    = 1'b0;
    case (state_q)
      IDLE: begin
        // Affordability is judged on the balance before this cycle's coin.
        if (start) begin
          if (!fine_block && (bal_q >= BAL_W'(sel_price))) begin
            bal_d       = bal_coin - BAL_W'(sel_price);
            lat_price_d = sel_price;
            lat_dur_d   = dur(32'(idx));
            rem_load    = 1'b1;
            state_d     = RUN;
          end else begin
            ins_d = 1'b1;
          end
        end
        if (price_wr)
          tbl_d[idx] = price_in;
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
          if (rem_cnt > (lat_dur_q >> 1))
            bal_d = sat_add(bal_coin, lat_price_q >> 1);
        end else if (rem_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (collect) begin
          state_d = IDLE;
          bal_d   = bal_coin - fine_ded;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bal_q       <= '0;
      ins_q       <= 1'b0;
      lat_price_q <= '0;
      lat_dur_q   <= '0;
      for (int i = 0; i < NUM_MODES; i++)
        tbl_q[i] <= def_price(i);
    end else begin
      state_q     <= state_d;
      bal_q       <= bal_d;
      ins_q       <= ins_d;
      lat_price_q <= lat_price_d;
      lat_dur_q   <= lat_dur_d;
      tbl_q       <= tbl_d;
    end
  end

  assign state        = state_q;
  assign balance      = bal_q;
  assign remaining    = rem_cnt;
  assign insufficient = ins_q;
  assign done         = (state_q == DONE);
endmodule
